// File: rtl/dadda_mac_pipe.sv
// Three-stage pipelined unsigned multiply-add (A*B+M) built on a Dadda reduction tree.
// Define DADDA_ACC_EN to add the running accumulator (acc_clr / ACC ports).
module dadda_mac_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2*WIDTH-1:0]   M,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH:0]     RES
`ifdef DADDA_ACC_EN
  ,
  input  logic                 acc_clr,
  output logic [ACC_W-1:0]     ACC
`endif
);

  localparam int unsigned NC   = 2*WIDTH+1;
  localparam int unsigned MAXH = WIDTH;
  localparam int unsigned CI   = $clog2(NC);
  localparam int unsigned HI   = $clog2(MAXH);
  localparam int unsigned WI   = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > 32 || ACC_W < 2*WIDTH+1) begin : g_param_chk
    $error("dadda_mac_pipe: illegal WIDTH/ACC_W");
  end

  // Bit matrix indexed [column][slot]; heights track occupied slots per column.
  typedef logic [NC-1:0][MAXH-1:0] mat_t;
  typedef int unsigned hgt_t [NC];

  function automatic int unsigned dseq(input int unsigned s);
    int unsigned d;
    d = 2;
    for (int unsigned i = 0; i < s; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic void pp_gen(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output mat_t mo, output hgt_t ho);
    int unsigned c;
    mo = '0;
    ho = '{default: 0};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        c = i + j;
        mo[CI'(c)][HI'(ho[CI'(c)])] = a[WI'(i)] & b[WI'(j)];
        ho[CI'(c)] = ho[CI'(c)] + 1;
      end
    end
  endfunction

  // One Dadda stage: per column, apply just enough half/full adders (carries from the
  // previous column counted first) to bring the height down to d, then pass the rest through.
  function automatic void dadda_step(input mat_t mi, input hgt_t hi, input int unsigned d,
                                     output mat_t mo, output hgt_t ho);
    int unsigned rem, rd;
    logic x, y, z, s, cy;
    mo = '0;
    ho = '{default: 0};
    for (int unsigned c = 0; c < NC; c++) begin
      rem = hi[CI'(c)];
      rd  = 0;
      for (int unsigned k = 0; k < MAXH; k++) begin
        if (rem + ho[CI'(c)] > d) begin
          x = mi[CI'(c)][HI'(rd)];
          y = mi[CI'(c)][HI'(rd+1)];
          if (rem + ho[CI'(c)] == d + 1) begin
            s   = x ^ y;
            cy  = x & y;
            rd  = rd + 2;
            rem = rem - 2;
          end else begin
            z   = mi[CI'(c)][HI'(rd+2)];
            s   = x ^ y ^ z;
            cy  = (x & y) | (x & z) | (y & z);
            rd  = rd + 3;
            rem = rem - 3;
          end
          mo[CI'(c)][HI'(ho[CI'(c)])] = s;
          ho[CI'(c)] = ho[CI'(c)] + 1;
          if (c + 1 < NC) begin
            mo[CI'(c+1)][HI'(ho[CI'(c+1)])] = cy;
            ho[CI'(c+1)] = ho[CI'(c+1)] + 1;
          end
        end
      end
      for (int unsigned k = 0; k < MAXH; k++) begin
        if (k < rem) begin
          mo[CI'(c)][HI'(ho[CI'(c)])] = mi[CI'(c)][HI'(rd+k)];
          ho[CI'(c)] = ho[CI'(c)] + 1;
        end
      end
    end
  endfunction

  logic              v1_q, v2_q, v3_q;
  logic [NC-1:0]     s1_r0_d, s1_r1_d, s1_r2_d;
  logic [NC-1:0]     s1_r0_q, s1_r1_q, s1_r2_q;
  logic [2*WIDTH-1:0] m1_q, m2_q;
  logic [NC-1:0]     s2_sum_d, s2_cry_d;
  logic [NC-1:0]     s2_sum_q, s2_cry_q;
  logic [NC-1:0]     res_d, res_q;
  logic              stall;

  assign stall     = v3_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3_q;
  assign RES       = res_q;

  always_comb begin : s1_reduce
    mat_t cm, nm;
    hgt_t ch, nh;
    nm = '0;
    nh = '{default: 0};
    pp_gen(A, B, cm, ch);
    for (int unsigned s = 8; s >= 1; s--) begin
      if (dseq(s) >= 3 && dseq(s) < MAXH) begin
        dadda_step(cm, ch, dseq(s), nm, nh);
        cm = nm;
        ch = nh;
      end
    end
    s1_r0_d = '0;
    s1_r1_d = '0;
    s1_r2_d = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      s1_r0_d[CI'(c)] = cm[CI'(c)][0];
      s1_r1_d[CI'(c)] = cm[CI'(c)][1];
      s1_r2_d[CI'(c)] = cm[CI'(c)][2];
    end
  end

  // Final height-3 -> 2 Dadda stage is one full adder per column.
  always_comb begin
    s2_sum_d = s1_r0_q ^ s1_r1_q ^ s1_r2_q;
    s2_cry_d = ((s1_r0_q & s1_r1_q) | (s1_r0_q & s1_r2_q) | (s1_r1_q & s1_r2_q)) << 1;
  end

  always_comb begin
    res_d = s2_sum_q + s2_cry_q + {1'b0, m2_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      res_q <= '0;
    end else if (!stall) begin
      v1_q     <= in_valid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      s1_r0_q  <= s1_r0_d;
      s1_r1_q  <= s1_r1_d;
      s1_r2_q  <= s1_r2_d;
      m1_q     <= M;
      s2_sum_q <= s2_sum_d;
      s2_cry_q <= s2_cry_d;
      m2_q     <= m1_q;
      res_q    <= res_d;
    end
  end

`ifdef DADDA_ACC_EN
  logic             xfer;
  logic [ACC_W-1:0] acc_d, acc_q;

  assign xfer = v3_q && out_ready;
  assign ACC  = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (xfer) acc_d = acc_clr ? ACC_W'(res_q) : acc_q + ACC_W'(res_q);
    else if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`endif

endmodule

// File: doc/dadda_mac_pipe.md
DADDA_MAC_PIPE -- requirements
Module: dadda_mac_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Parameter: ACC_W, default 2*WIDTH+8, accumulator width; SHALL be >= 2*WIDTH+1.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset; synchronous and active-high.
REQ-005 Port: in_valid  in  1  operand set present.
REQ-006 Port: in_ready  out  1  block accepts operands this cycle.
REQ-007 Port: A  in  WIDTH  unsigned multiplicand.
REQ-008 Port: B  in  WIDTH  unsigned multiplier.
REQ-009 Port: M  in  2*WIDTH  unsigned addend.
REQ-010 Port: out_valid  out  1  RES holds a valid result.
REQ-011 Port: out_ready  in  1  consumer accepts RES this cycle.
REQ-012 Port: RES  out  2*WIDTH+1  A*B+M, exact.
REQ-013 Port: acc_clr  in  1  clear accumulator; present only with DADDA_ACC_EN.
REQ-014 Port: ACC  out  ACC_W  running sum of accepted RES; present only with DADDA_ACC_EN.

Function
REQ-015 Accept: operands captured when in_valid && in_ready.
REQ-016 Output transfer: occurs when out_valid && out_ready.
REQ-017 Arithmetic: RES SHALL equal A*B+M zero-extended to 2*WIDTH+1 bits; no overflow possible.
REQ-018 Pipeline: 3 registered stages:
- S1: partial-product generation plus Dadda reduction down to height 3.
- S2: reduction to 2 rows.
- S3: final carry-propagate add of both rows with M.
REQ-019 Latency: an accepted operand set SHALL appear on RES with out_valid=1 exactly 3 cycles after acceptance when no stall occurs.
REQ-020 Throughput: one accept per cycle while unstalled.
REQ-021 Stall condition: stall = out_valid && !out_ready.
REQ-022 Stall effect: all stage registers and valid bits hold.
REQ-023 Ready: in_ready SHALL equal !stall; combinational; no bubble collapsing.
REQ-024 Ordering: results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-025 Held output: while stalled, RES and out_valid SHALL remain stable.
REQ-026 Empty slots: RES value is don't-care when out_valid=0.

Reset
REQ-027 On clk edge with rst=1: all stage valid bits cleared; out_valid=0, RES=0, ACC=0.
REQ-028 in_ready during reset: SHALL be 1 during and after reset, since out_valid=0.
REQ-029 Reset mid-operation: in-flight results SHALL be discarded; no out_valid pulse for them after reset is released.
REQ-030 Inputs during reset: in_valid asserted in a cycle with rst=1 SHALL NOT be accepted.

Configuration
REQ-031 Macro DADDA_ACC_EN defined:
- ACC register present, ACC_W bits.
- Output transfer: ACC <= ACC + RES, wrapping modulo 2^ACC_W.
- acc_clr=1 without transfer: ACC <= 0.
- acc_clr=1 with transfer in the same cycle: ACC <= RES zero-extended.
- ACC updates one cycle after the transfer edge and is registered.
REQ-032 Macro DADDA_ACC_EN undefined: ACC, acc_clr and the accumulator logic are absent; all other behaviour is identical.

Verification
REQ-033 Basic 8x8 (WIDTH=8, out_ready=1):
- A=00,B=00,M=0000 -> RES=00000.
- A=FF,B=AA,M=0000 -> RES=0A956, exactly 3 cycles after accept.
REQ-034 Boundary: A=FF,B=FF,M=FFFF -> RES=1FE00; A=FF,B=FF,M=0 -> RES=0FE01.
REQ-035 Backpressure:
- Stimulus: 5 back-to-back accepts; out_ready=0 for 4 cycles after the first out_valid.
- Required: in_ready=0 throughout the stall, RES held, all 5 results in order with none lost.
REQ-036 Reset mid-op: 2 operand sets in flight, rst=1 for 1 cycle -> out_valid stays 0, and the next accepted set has latency 3.
REQ-037 Width sweep: WIDTH=16, 1000 random A/B/M vectors compared against a behavioural A*B+M; includes A=FFFF,B=FFFF,M=FFFFFFFF -> RES=1FFFE0000.
REQ-038 Accumulator (DADDA_ACC_EN, WIDTH=8):
- Three transfers of 0FE01 -> ACC=02FA03.
- acc_clr together with a transfer of 0A956 -> ACC=00A956.
- ACC_W=17 wrap: 1FE00+1FE00 -> ACC=1FC00.
